// File: rtl/output_port_scheduler_if.sv
// Handshake bundle between the input VC requesters and one output port scheduler.
// The scheduler side uses the slave modport; requesters and downstream credit logic use master.
interface output_port_scheduler_if #(
  parameter int REQ_NUM      = 4,
  parameter int CREDIT_DEPTH = 4
);
  localparam int REQ_BCD_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CREDIT_WIDTH  = $clog2(CREDIT_DEPTH + 1);

  logic [REQ_NUM-1:0]       request;
  logic [REQ_NUM-1:0]       tail_flag;
  logic                     credit_in;
  logic                     grant_valid;
  logic [REQ_NUM-1:0]       grant_onehot;
  logic [REQ_BCD_WIDTH-1:0] grant_bcd;
  logic                     locked;
  logic [CREDIT_WIDTH-1:0]  credit_count;
  logic                     credit_err;
  logic [15:0]              pkt_count;

  modport master (
    output request, tail_flag, credit_in,
    input  grant_valid, grant_onehot, grant_bcd, locked,
    input  credit_count, credit_err, pkt_count
  );

  modport slave (
    input  request, tail_flag, credit_in,
    output grant_valid, grant_onehot, grant_bcd, locked,
    output credit_count, credit_err, pkt_count
  );
endinterface

// File: rtl/output_port_scheduler.sv
// Wormhole round-robin scheduler for one router output port with downstream credit gating.
// Optional tail-flit packet counter is built only when macro PKT_COUNT_EN is defined.
module output_port_scheduler #(
  parameter int REQ_NUM      = 4,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output_port_scheduler_if.slave bus
);
  localparam int REQ_BCD_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CREDIT_WIDTH  = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_FULL = CREDIT_WIDTH'(CREDIT_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                   state_q, state_d;
  logic [REQ_BCD_WIDTH-1:0] owner_q, owner_d;
  logic [REQ_NUM-1:0]       mask_q, mask_d;
  logic [CREDIT_WIDTH-1:0]  credit_q, credit_d;
  logic                     err_q, err_d;

  logic [REQ_NUM-1:0]       masked_req;
  logic [REQ_BCD_WIDTH-1:0] masked_win, any_win, winner;
  logic [REQ_NUM-1:0]       mask_above;
  logic                     credit_avail;
  logic                     grant_valid;
  logic [REQ_BCD_WIDTH-1:0] grant_bcd;
  logic [REQ_NUM-1:0]       grant_onehot;

  assign masked_req   = bus.request & mask_q;
  assign credit_avail = (credit_q != '0);

  // Lowest set index wins; the masked search gives round-robin fairness, plain search wraps around.
  always_comb begin
    masked_win = '0;
    any_win    = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (masked_req[i]) masked_win = REQ_BCD_WIDTH'(i);
      if (bus.request[i]) any_win = REQ_BCD_WIDTH'(i);
    end
    winner = (|masked_req) ? masked_win : any_win;
    for (int i = 0; i < REQ_NUM; i++) begin
      mask_above[i] = (i > int'(winner));
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mask_d      = mask_q;
    grant_valid = 1'b0;
    grant_bcd   = '0;
    unique case (state_q)
      IDLE: begin
        if ((|bus.request) && credit_avail) begin
          grant_valid = 1'b1;
          grant_bcd   = winner;
          mask_d      = mask_above;
          if (!bus.tail_flag[winner]) begin
            state_d = LOCKED;
            owner_d = winner;
          end
        end
      end
      LOCKED: begin
        grant_bcd = owner_q;
        if (bus.request[owner_q] && credit_avail) begin
          grant_valid = 1'b1;
          if (bus.tail_flag[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle never transfers a flit, even if state still shows an owner.
    if (reset) begin
      grant_valid = 1'b0;
      grant_bcd   = '0;
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (grant_valid) grant_onehot = REQ_NUM'(1) << grant_bcd;
  end

  // A credit returned while the counter is already full is a protocol error; hold the count.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    unique case ({grant_valid, bus.credit_in})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CREDIT_FULL) err_d = 1'b1;
        else credit_d = credit_q + 1'b1;
      end
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      mask_q   <= '1;
      credit_q <= CREDIT_FULL;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      mask_q   <= mask_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

`ifdef PKT_COUNT_EN
  logic [15:0] pkt_q;

  always_ff @(posedge clk) begin
    if (reset) pkt_q <= 16'd0;
    else if (grant_valid && bus.tail_flag[grant_bcd]) pkt_q <= pkt_q + 16'd1;
  end

  assign bus.pkt_count = pkt_q;
`else
  assign bus.pkt_count = 16'd0;
`endif

  assign bus.grant_valid  = grant_valid;
  assign bus.grant_onehot = grant_onehot;
  assign bus.grant_bcd    = grant_bcd;
  assign bus.locked       = (state_q == LOCKED);
  assign bus.credit_count = credit_q;
  assign bus.credit_err   = err_q;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Scoreboard bench for output_port_scheduler: a reference model pushes expected outputs per cycle.
// Directed scenarios cover round-robin, wormhole hold, credit stall, credit error, reset and pkt_count.
module tb_output_port_scheduler;
  localparam int REQ_NUM = 4;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic        gv;
    logic [3:0]  oh;
    logic [1:0]  bcd;
    logic        lk;
    logic [2:0]  cc;
    logic        err;
    logic [15:0] pkt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  exp_t obs;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit       m_locked;
  int       m_owner;
  bit [3:0] m_mask;
  int       m_cc;
  bit       m_err;
  int       m_pkt;

  output_port_scheduler_if #(.REQ_NUM(REQ_NUM), .CREDIT_DEPTH(DEPTH)) bus ();

  output_port_scheduler #(.REQ_NUM(REQ_NUM), .CREDIT_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_mask   = 4'b1111;
    m_cc     = DEPTH;
    m_err    = 1'b0;
    m_pkt    = 0;
  endtask

  // Reference model: combinational result for this cycle, then state advance at the clock edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] tail, input logic cin, input logic rst);
    exp_t e;
    exp_t got;
    bit   gv;
    int   idx;
    int   win;
    reset           = rst;
    bus.request     = req;
    bus.tail_flag   = tail;
    bus.credit_in   = cin;
    gv  = 1'b0;
    idx = 0;
    win = -1;
    if (m_locked) begin
      idx = m_owner;
      gv  = req[m_owner] && (m_cc > 0);
    end else begin
      for (int i = 0; i < REQ_NUM && win < 0; i++) if (req[i] && m_mask[i]) win = i;
      for (int i = 0; i < REQ_NUM && win < 0; i++) if (req[i]) win = i;
      gv  = (win >= 0) && (m_cc > 0);
      idx = gv ? win : 0;
    end
    if (rst) begin
      gv  = 1'b0;
      idx = 0;
    end
    e.gv  = gv;
    e.oh  = gv ? (4'b0001 << idx) : 4'b0000;
    e.bcd = 2'(idx);
    e.lk  = m_locked;
    e.cc  = 3'(m_cc);
    e.err = m_err;
    e.pkt = 16'(m_pkt);
    sb_q.push_back(e);

    @(negedge clk);
    obs = '{bus.grant_valid, bus.grant_onehot, bus.grant_bcd, bus.locked,
            bus.credit_count, bus.credit_err, bus.pkt_count};
    if (sb_q.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      checkOutput("grant_valid",  32'(obs.gv),  32'(got.gv));
      checkOutput("grant_onehot", 32'(obs.oh),  32'(got.oh));
      checkOutput("grant_bcd",    32'(obs.bcd), 32'(got.bcd));
      checkOutput("locked",       32'(obs.lk),  32'(got.lk));
      checkOutput("credit_count", 32'(obs.cc),  32'(got.cc));
      checkOutput("credit_err",   32'(obs.err), 32'(got.err));
      checkOutput("pkt_count",    32'(obs.pkt), 32'(got.pkt));
    end

    @(posedge clk);
    if (rst) begin
      modelReset();
    end else begin
      if (gv && !cin) m_cc--;
      else if (!gv && cin) begin
        if (m_cc == DEPTH) m_err = 1'b1;
        else m_cc++;
      end
`ifdef PKT_COUNT_EN
      if (gv && tail[idx]) m_pkt = (m_pkt + 1) % 65536;
`endif
      if (!m_locked && gv) begin
        m_mask = 4'b0000;
        for (int i = 0; i < REQ_NUM; i++) if (i > idx) m_mask[i] = 1'b1;
        if (!tail[idx]) begin
          m_locked = 1'b1;
          m_owner  = idx;
        end
      end else if (m_locked && gv && tail[m_owner]) begin
        m_locked = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    bus.request   = '0;
    bus.tail_flag = '0;
    bus.credit_in = 1'b0;
    @(posedge clk);
    #1;
    modelReset();

    // Reset state
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("rst_credit", 32'(obs.cc), 32'd4);
    checkOutput("rst_locked", 32'(obs.lk), 32'd0);

    // Round-robin among requesters 1 and 3
    applyStimulus(4'b1010, 4'b1010, 1'b1, 1'b0);
    checkOutput("rr_first", 32'(obs.bcd), 32'd1);
    applyStimulus(4'b1010, 4'b1010, 1'b1, 1'b0);
    checkOutput("rr_second", 32'(obs.bcd), 32'd3);
    applyStimulus(4'b1010, 4'b1010, 1'b1, 1'b0);
    checkOutput("rr_wrap", 32'(obs.bcd), 32'd1);

    // Requester 0 holds the port for a 3-flit packet while requester 2 waits
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0101, (i == 2) ? 4'b0101 : 4'b0100, 1'b1, 1'b0);
      checkOutput("worm_owner", 32'(obs.bcd), 32'd0);
    end
    applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0);
    checkOutput("worm_next", 32'(obs.bcd), 32'd2);

    // Credit exhaustion mid-packet, then a single returned credit
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    checkOutput("stall_gv", 32'(obs.gv), 32'd0);
    checkOutput("stall_cc", 32'(obs.cc), 32'd0);
    checkOutput("stall_lk", 32'(obs.lk), 32'd1);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
    checkOutput("zero_no_grant", 32'(obs.gv), 32'd0);
    applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b0);
    checkOutput("credit_reuse", 32'(obs.gv), 32'd1);
    applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0);
    checkOutput("grant_cin_cc", 32'(obs.cc), 32'd1);
    checkOutput("grant_cin_err", 32'(obs.err), 32'd0);

    // Overflowing credit sets the sticky error
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("ovf_cc", 32'(obs.cc), 32'd4);
    checkOutput("ovf_err", 32'(obs.err), 32'd1);

    // Reset while locked mid-packet
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b1);
    checkOutput("rst_cycle_gv", 32'(obs.gv), 32'd0);
    applyStimulus(4'b1001, 4'b1001, 1'b0, 1'b0);
    checkOutput("post_rst_lk", 32'(obs.lk), 32'd0);
    checkOutput("post_rst_cc", 32'(obs.cc), 32'd4);
    checkOutput("post_rst_prio", 32'(obs.bcd), 32'd0);
    applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
    checkOutput("post_rst_req3", 32'(obs.bcd), 32'd3);

    // Five single-flit packets
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
`ifdef PKT_COUNT_EN
    checkOutput("pkt_five", 32'(obs.pkt), 32'd5);
`else
    checkOutput("pkt_tied", 32'(obs.pkt), 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
      if (obs.gv) checkOutput("onehot_bcd", 32'(obs.oh), 32'(4'b0001 << obs.bcd));
    end

    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
